// File: rtl/nubus_pkg.sv
// NuBus master shared types: sequencer states and final-status codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nubus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ARBDN,
    ADDR,
    DATA,
    NULL,
    END
  } nub_state_e;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b11;

endpackage

// File: rtl/nubus_wdt.sv
// Data-phase watchdog: counts clocks while enabled and flags when bit WDT_W sets.
// Latency: fire_o rises 2**WDT_W clocks after en_i first samples high.
// Backpressure: none; the counter clears the clock after en_i drops.
module nubus_wdt #(
  parameter int WDT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic fire_o
);

  logic [WDT_W:0] cnt_q;
  logic [WDT_W:0] cnt_d;

  // Count while enabled, hold once fired, restart from zero when disabled
  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = cnt_q[WDT_W] ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire_o = cnt_q[WDT_W];

endmodule

// File: rtl/nubus_master_seq.sv
// NuBus master sequencer: arbitration, address, block data beats, NULL-ATTN, status decode.
// Latency: all outputs registered; they follow the state entered on each nub_clkn edge.
// Backpressure: holds ARBDN until granted and the bus is free; DATA ends on ACK or watchdog.
// Optional: define NUBUS_MASTER_RETRY_EN to re-run try-again transfers up to 2**RETRY_W-1 times.
module nubus_master_seq
  import nubus_pkg::*;
#(
  parameter int WDT_W   = 8,
  parameter int BLK_W   = 3,
  parameter int RETRY_W = 4
) (
  input  logic             nub_clkn,
  input  logic             nub_reset,
  input  logic             nub_rqstn,
  input  logic             nub_startn,
  input  logic             nub_ackn,
  input  logic             nub_tm0n,
  input  logic             nub_tm1n,
  input  logic             arb_grant,
  input  logic             cpu_req,
  input  logic             cpu_lock,
  input  logic [BLK_W-1:0] cpu_blk_len,
  output logic             mst_arbcyn_o,
  output logic             mst_arbdn_o,
  output logic             mst_busyn_o,
  output logic             mst_ownern_o,
  output logic             mst_adrcyn_o,
  output logic             mst_dtacyn_o,
  output logic             mst_lockedn_o,
  output logic             mst_beat_o,
  output logic [BLK_W-1:0] mst_beat_idx_o,
  output logic             mst_done_o,
  output logic [1:0]       mst_status_o,
  output logic             mst_timeout_o
);

  nub_state_e       state_q, state_d;
  logic             lock_q, lock_d;
  logic [BLK_W-1:0] len_q, len_d;
  logic [BLK_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] beat_idx_q, beat_idx_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic [1:0]       status_q, status_d;
  logic             beat_q, beat_d;
  logic             tmo_q, tmo_d;
  logic             arbcyn_q, arbdnn_q, ownern_q, adrcyn_q, dtacyn_q, done_q;
  logic             fin;
  logic [1:0]       fin_st;
  logic             wdt_en;
  logic             wdt_fire;

`ifdef NUBUS_MASTER_RETRY_EN
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  // The watchdog runs from the first DATA clock, so it fires on DATA clock 2**WDT_W
  assign wdt_en = (state_d == DATA);

  nubus_wdt #(.WDT_W(WDT_W)) u_wdt (
    .clk_i  (nub_clkn),
    .rst_i  (nub_reset),
    .en_i   (wdt_en),
    .fire_o (wdt_fire)
  );

  // Next-state, bus monitor and data-phase decode
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    len_d      = len_q;
    idx_d      = idx_q;
    beat_idx_d = beat_idx_q;
    locked_d   = locked_q;
    status_d   = status_q;
    beat_d     = 1'b0;
    tmo_d      = 1'b0;
    fin        = 1'b0;
    fin_st     = ST_OK;
`ifdef NUBUS_MASTER_RETRY_EN
    retry_d    = retry_q;
`endif
    // A START we did not drive marks a foreign transaction until its ACK
    busy_d = busy_q;
    if (!nub_startn && nub_ackn && !(state_q == ADDR || state_q == NULL)) begin
      busy_d = 1'b1;
    end else if (!nub_ackn || wdt_fire) begin
      busy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cpu_req && nub_rqstn) begin
          state_d = ARB;
          lock_d  = cpu_lock;
          len_d   = cpu_blk_len;
          idx_d   = '0;
`ifdef NUBUS_MASTER_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      ARB: begin
        // A START during the settle delay restarts it
        if (nub_startn) begin
          state_d = ARBDN;
        end
      end
      ARBDN: begin
        if (arb_grant && ((!busy_q && nub_startn) || (busy_q && !nub_ackn))) begin
          state_d = ADDR;
          if (lock_q) begin
            locked_d = 1'b1;
          end
        end
      end
      ADDR: state_d = DATA;
      DATA: begin
        // ACK beats the watchdog; an ACK before the last beat is an early end
        if (!nub_ackn) begin
          fin        = 1'b1;
          fin_st     = (idx_q < len_q) ? ST_ERR : {~nub_tm1n, ~nub_tm0n};
          beat_d     = 1'b1;
          beat_idx_d = idx_q;
        end else if (wdt_fire) begin
          fin    = 1'b1;
          fin_st = ST_TMO;
          tmo_d  = 1'b1;
        end else if (!nub_tm0n && (idx_q < len_q)) begin
          beat_d     = 1'b1;
          beat_idx_d = idx_q;
          idx_d      = idx_q + 1'b1;
        end
        if (fin) begin
          status_d = fin_st;
          state_d  = lock_q ? NULL : END;
`ifdef NUBUS_MASTER_RETRY_EN
          if (fin_st == ST_RETRY && retry_q != RETRY_MAX) begin
            state_d = ARB;
            retry_d = retry_q + 1'b1;
            idx_d   = '0;
          end
`endif
        end
      end
      NULL: begin
        state_d  = END;
        locked_d = 1'b0;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered bus-control outputs
  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      beat_idx_q <= '0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      status_q   <= ST_OK;
      beat_q     <= 1'b0;
      tmo_q      <= 1'b0;
      arbcyn_q   <= 1'b1;
      arbdnn_q   <= 1'b1;
      ownern_q   <= 1'b1;
      adrcyn_q   <= 1'b1;
      dtacyn_q   <= 1'b1;
      done_q     <= 1'b0;
`ifdef NUBUS_MASTER_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      beat_idx_q <= beat_idx_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      status_q   <= status_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      arbcyn_q   <= !(state_d == ARB || state_d == ARBDN);
      arbdnn_q   <= (state_d != ARBDN);
      ownern_q   <= !(state_d == ADDR || state_d == DATA || state_d == NULL);
      adrcyn_q   <= !(state_d == ADDR || state_d == NULL);
      dtacyn_q   <= (state_d != DATA);
      done_q     <= (state_d == END);
`ifdef NUBUS_MASTER_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign mst_arbcyn_o   = arbcyn_q;
  assign mst_arbdn_o    = arbdnn_q;
  assign mst_busyn_o    = ~busy_q;
  assign mst_ownern_o   = ownern_q;
  assign mst_adrcyn_o   = adrcyn_q;
  assign mst_dtacyn_o   = dtacyn_q;
  assign mst_lockedn_o  = ~locked_q;
  assign mst_beat_o     = beat_q;
  assign mst_beat_idx_o = beat_idx_q;
  assign mst_done_o     = done_q;
  assign mst_status_o   = status_q;
  assign mst_timeout_o  = tmo_q;

endmodule

// File: tb/tb_nubus_master_seq.sv
// Directed bench for nubus_master_seq (WDT_W=4, BLK_W=3, RETRY_W=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_nubus_master_seq;

  logic       clk = 1'b0;
  logic       rst, rqstn, startn, ackn, tm0n, tm1n, grant, cpu_req, cpu_lock;
  logic [2:0] cpu_len;
  logic       arbcyn, arbdnn, busyn, ownern, adrcyn, dtacyn, lockedn, beat, done, tmo;
  logic [2:0] idx;
  logic [1:0] status;
  logic [14:0] outs;
  int checks = 0;
  int errors = 0;

  localparam logic [14:0] RESET_OUTS = 15'b111_1111_0_000_0_00_0;

  assign outs = {arbcyn, arbdnn, busyn, ownern, adrcyn, dtacyn, lockedn, beat, idx, done, status, tmo};

  always #5 clk = ~clk;

  nubus_master_seq #(.WDT_W(4), .BLK_W(3), .RETRY_W(2)) dut (
    .nub_clkn       (clk),
    .nub_reset      (rst),
    .nub_rqstn      (rqstn),
    .nub_startn     (startn),
    .nub_ackn       (ackn),
    .nub_tm0n       (tm0n),
    .nub_tm1n       (tm1n),
    .arb_grant      (grant),
    .cpu_req        (cpu_req),
    .cpu_lock       (cpu_lock),
    .cpu_blk_len    (cpu_len),
    .mst_arbcyn_o   (arbcyn),
    .mst_arbdn_o    (arbdnn),
    .mst_busyn_o    (busyn),
    .mst_ownern_o   (ownern),
    .mst_adrcyn_o   (adrcyn),
    .mst_dtacyn_o   (dtacyn),
    .mst_lockedn_o  (lockedn),
    .mst_beat_o     (beat),
    .mst_beat_idx_o (idx),
    .mst_done_o     (done),
    .mst_status_o   (status),
    .mst_timeout_o  (tmo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Request a transfer and advance to the first DATA clock
  task automatic go_data(input logic lk, input logic [2:0] ln, output bit ok);
    cpu_lock = lk; cpu_len = ln; grant = 1'b1; cpu_req = 1'b1;
    tick;
    cpu_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!dtacyn) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++;
    if (outs !== RESET_OUTS) begin errors++; $display("FAIL reset_outputs: got %b want %b", outs, RESET_OUTS); end
    rst = 1'b0;
    tick;
    checks++;
    if (outs !== RESET_OUTS) begin errors++; $display("FAIL idle_no_req: got %b want %b", outs, RESET_OUTS); end
  endtask

  task automatic test_single;
    int n_dta;
    cpu_lock = 1'b0; cpu_len = 3'd0; grant = 1'b1; cpu_req = 1'b1;
    tick;
    cpu_req = 1'b0;
    checks++;
    if ({arbcyn, arbdnn} !== 2'b01) begin errors++; $display("FAIL arb_phase: arbcyn/arbdn %b want 01", {arbcyn, arbdnn}); end
    tick;
    checks++;
    if ({arbcyn, arbdnn} !== 2'b00) begin errors++; $display("FAIL arbdn_phase: arbcyn/arbdn %b want 00", {arbcyn, arbdnn}); end
    tick;
    checks++;
    if ({arbcyn, ownern, adrcyn, dtacyn} !== 4'b1001) begin
      errors++; $display("FAIL addr_phase: arbcyn/owner/adrcy/dtacy %b want 1001", {arbcyn, ownern, adrcyn, dtacyn});
    end
    tick;
    checks++;
    if ({adrcyn, dtacyn} !== 2'b10) begin errors++; $display("FAIL addr_one_clk: adrcy/dtacy %b want 10", {adrcyn, dtacyn}); end
    n_dta = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (!dtacyn) n_dta++;
    end
    ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if (n_dta !== 4 || dtacyn !== 1'b1) begin errors++; $display("FAIL dtacy_len: got %0d clks want 4", n_dta); end
    checks++;
    if ({done, status, beat, idx, ownern} !== 8'b1_00_1_000_1) begin
      errors++; $display("FAIL single_done: done/status/beat/idx/owner %b want 10010001", {done, status, beat, idx, ownern});
    end
    tick;
    checks++;
    if ({done, arbcyn, beat} !== 3'b010) begin errors++; $display("FAIL single_idle: done/arbcyn/beat %b want 010", {done, arbcyn, beat}); end
  endtask

  task automatic test_block;
    bit ok;
    int nb;
    go_data(1'b0, 3'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL block_reach_data: got no DATA want DATA within 20 clks"); end
    tm0n = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tick;
      checks++;
      if ({beat, idx, done} !== {1'b1, 3'(b), 1'b0}) begin
        errors++; $display("FAIL block_beat%0d: beat/idx/done %b want %b", b, {beat, idx, done}, {1'b1, 3'(b), 1'b0});
      end
    end
    tm0n = 1'b1; ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if ({done, beat, idx, status} !== 7'b1_1_011_00) begin
      errors++; $display("FAIL block_final: done/beat/idx/status %b want 1101100", {done, beat, idx, status});
    end
    tick;
    // ACK on the first beat of a 4-beat block
    go_data(1'b0, 3'd3, ok);
    ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if ({done, status} !== 3'b1_01) begin errors++; $display("FAIL early_end: done/status %b want 101", {done, status}); end
    tick;
    // Extra intermediate acks once idx reaches len must not pulse
    go_data(1'b0, 3'd1, ok);
    tm0n = 1'b0;
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (beat) nb++;
    end
    checks++;
    if (nb !== 1 || done !== 1'b0 || idx !== 3'd0) begin
      errors++; $display("FAIL idx_saturate: beats %0d idx %0d done %b want 1 0 0", nb, idx, done);
    end
    tm0n = 1'b1; ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if ({done, idx, status} !== 6'b1_001_00) begin errors++; $display("FAIL sat_final: done/idx/status %b want 100100", {done, idx, status}); end
    tick;
  endtask

  task automatic test_locked;
    bit ok;
    go_data(1'b1, 3'd0, ok);
    checks++;
    if (!ok || lockedn !== 1'b0) begin errors++; $display("FAIL locked_in_data: reached %b lockedn %b want 1 0", ok, lockedn); end
    ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if ({adrcyn, lockedn, ownern, dtacyn, done} !== 5'b00010) begin
      errors++; $display("FAIL null_attn: adrcy/locked/owner/dtacy/done %b want 00010", {adrcyn, lockedn, ownern, dtacyn, done});
    end
    tick;
    checks++;
    if ({done, lockedn, adrcyn, ownern} !== 4'b1111) begin
      errors++; $display("FAIL locked_end: done/locked/adrcy/owner %b want 1111", {done, lockedn, adrcyn, ownern});
    end
    tick;
  endtask

  task automatic test_busy;
    startn = 1'b0;
    tick;
    startn = 1'b1;
    checks++;
    if (busyn !== 1'b0) begin errors++; $display("FAIL busy_set: busyn %b want 0", busyn); end
    cpu_lock = 1'b0; cpu_len = 3'd0; grant = 1'b0; cpu_req = 1'b1;
    tick;
    cpu_req = 1'b0;
    tick; tick;
    checks++;
    if ({arbdnn, adrcyn} !== 2'b01) begin errors++; $display("FAIL lost_grant: arbdn/adrcy %b want 01", {arbdnn, adrcyn}); end
    grant = 1'b1;
    tick;
    checks++;
    if ({arbdnn, adrcyn, busyn} !== 3'b010) begin errors++; $display("FAIL busy_hold: arbdn/adrcy/busy %b want 010", {arbdnn, adrcyn, busyn}); end
    ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if ({adrcyn, busyn} !== 2'b01) begin errors++; $display("FAIL addr_after_ack: adrcy/busy %b want 01", {adrcyn, busyn}); end
    tick;
    ackn = 1'b0;
    tick;
    ackn = 1'b1;
    tick;
  endtask

  task automatic test_watchdog;
    bit ok;
    bit early;
    int n;
    go_data(1'b0, 3'd0, ok);
    n = 1; early = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (!dtacyn) n++;
      if (done) break;
      if (tmo) early = 1'b1;
    end
    checks++;
    if (n !== 16 || early) begin errors++; $display("FAIL wdt_len: dtacy %0d clks early %b want 16 0", n, early); end
    checks++;
    if ({done, status, tmo} !== 4'b1_10_1) begin errors++; $display("FAIL wdt_done: done/status/tmo %b want 1101", {done, status, tmo}); end
    tick;
    checks++;
    if ({done, tmo, arbcyn, dtacyn} !== 4'b0011) begin
      errors++; $display("FAIL wdt_idle: done/tmo/arbcyn/dtacy %b want 0011", {done, tmo, arbcyn, dtacyn});
    end
    // ACK arriving on the very clock the watchdog fires
    go_data(1'b0, 3'd0, ok);
    for (int k = 0; k < 15; k++) tick;
    ackn = 1'b0;
    tick;
    ackn = 1'b1;
    checks++;
    if ({done, status, tmo} !== 4'b1_00_0) begin errors++; $display("FAIL ack_beats_wdt: done/status/tmo %b want 1000", {done, status, tmo}); end
    tick;
  endtask

  task automatic test_retry;
    bit ok;
    int n_adr, n_arb, exp_adr, exp_arb;
`ifdef NUBUS_MASTER_RETRY_EN
    exp_adr = 4; exp_arb = 3;
`else
    exp_adr = 1; exp_arb = 0;
`endif
    go_data(1'b0, 3'd0, ok);
    n_adr = 1; n_arb = 0;
    for (int k = 0; k < 200; k++) begin
      ackn = dtacyn; tm0n = dtacyn; tm1n = dtacyn;
      tick;
      if (!adrcyn) n_adr++;
      if (!arbcyn && arbdnn) n_arb++;
      if (done) break;
    end
    ackn = 1'b1; tm0n = 1'b1; tm1n = 1'b1;
    checks++;
    if (n_adr !== exp_adr || n_arb !== exp_arb) begin
      errors++; $display("FAIL retry_count: addr %0d arb %0d want %0d %0d", n_adr, n_arb, exp_adr, exp_arb);
    end
    checks++;
    if ({done, status} !== 3'b1_11) begin errors++; $display("FAIL retry_done: done/status %b want 111", {done, status}); end
    tick;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    go_data(1'b0, 3'd0, ok);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (outs !== RESET_OUTS) begin errors++; $display("FAIL reset_mid: got %b want %b", outs, RESET_OUTS); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (done || !arbcyn) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_done: activity %b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; rqstn = 1'b1; startn = 1'b1; ackn = 1'b1; tm0n = 1'b1; tm1n = 1'b1;
    grant = 1'b0; cpu_req = 1'b0; cpu_lock = 1'b0; cpu_len = 3'd0;
    test_reset;
    test_single;
    test_block;
    test_locked;
    test_busy;
    test_watchdog;
    test_retry;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
